// File: rtl/pipe_stage_buf.sv
// Valid/ready pipeline buffer: circular FIFO of DEPTH entries with optional zero-latency bypass when empty.
// Stall freezes all state; flush and reset empty the buffer at the next edge, flush overriding stall and traffic.
module pipe_stage_buf #(
   parameter int WIDTH  = 32,
   parameter int DEPTH  = 2,
   parameter int BYPASS = 0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [WIDTH-1:0]           in_data,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH-1:0]           out_data,
   input  logic                       stall,
   input  logic                       flush,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       full,
   output logic                       empty
);
   localparam int CW = $clog2(DEPTH + 1);
   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [PW-1:0] LAST_PTR = PW'(DEPTH - 1);
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             active;
   logic             bypass_hit;
   logic             enq;
   logic             deq;

   // Pointers wrap explicitly so non-power-of-two depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == LAST_PTR) ? '0 : p + 1'b1;
   endfunction

   always_comb begin
      active     = !reset && !stall && !flush;
      full       = (count_q == FULL_CNT);
      empty      = (count_q == '0);
      count      = count_q;
      bypass_hit = (BYPASS != 0) && empty && in_valid && out_ready && active;
      // in_ready is a function of state and local controls only, never of out_ready.
      in_ready   = !full && active;
      out_valid  = (!empty || bypass_hit) && active;
      enq        = in_valid && in_ready && !bypass_hit;
      deq        = out_valid && out_ready && !bypass_hit;
      out_data   = bypass_hit ? in_data : mem_q[rd_ptr_q];

      rd_ptr_d = deq ? ptr_inc(rd_ptr_q) : rd_ptr_q;
      wr_ptr_d = enq ? ptr_inc(wr_ptr_q) : wr_ptr_q;
      count_d  = count_q;
      case ({enq, deq})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage is not reset; contents are only observable behind a nonzero count.
   always_ff @(posedge clk) begin
      if (enq) begin
         mem_q[wr_ptr_q] <= in_data;
      end
   end
endmodule
